aoi211_bist_ctrl: RTL

- Built-in self-test sequencer for one aoi211 cell instance (function ZN = !((A1&A2)|B|C)).
- Drives the cell's four inputs through all 16 combinations, waits a programmable settle time, samples ZN and compares it with the expected value.
- Reports pass/fail, the failure count and the first failing vector.
- Sits beside the cell under test in the library characterization/silicon-monitor harness.

---
 rtl/aoi211_bist_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aoi211_bist_ctrl.sv
// Built-in self-test sequencer for a single aoi211 cell (ZN = !((A1&A2)|B|C)).
// Walks all 16 input vectors, lets each settle, samples ZN and records mismatches.
module aoi211_bist_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned SETTLE_W   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic       ZN_DUT,
    output logic       A1,
    output logic       A2,
    output logic       B,
    output logic       C,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] FAIL_CNT,
    output logic [3:0] FAIL_VEC
);

    localparam int unsigned VEC_W  = 4;
    localparam int unsigned FCNT_W = 5;

    if (SETTLE_CYC == 0 || SETTLE_CYC > 15) begin : g_bad_settle_cyc
        $error("aoi211_bist_ctrl: SETTLE_CYC must be in 1..15");
    end
    if (SETTLE_W < 32 && SETTLE_CYC > ((2 ** SETTLE_W) - 1)) begin : g_bad_settle_w
        $error("aoi211_bist_ctrl: SETTLE_W too narrow for SETTLE_CYC");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [VEC_W-1:0]    r_vec;
    logic [VEC_W-1:0]    w_vec_nxt;
    logic [VEC_W-1:0]    r_stim;
    logic [VEC_W-1:0]    w_stim_nxt;
    logic [SETTLE_W-1:0] r_cnt;
    logic [SETTLE_W-1:0] w_cnt_nxt;
    logic [FCNT_W-1:0]   r_fail_cnt;
    logic [FCNT_W-1:0]   w_fail_cnt_nxt;
    logic [VEC_W-1:0]    r_fail_vec;
    logic [VEC_W-1:0]    w_fail_vec_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;

    logic                w_settle_last;
    logic                w_vec_last;
    logic                w_exp_zn;
    logic                w_mismatch;

    assign w_settle_last = (r_cnt == SETTLE_W'(SETTLE_CYC - 1));
    assign w_vec_last    = (r_vec == VEC_W'(15));
    assign w_exp_zn      = ~((r_vec[3] & r_vec[2]) | r_vec[1] | r_vec[0]);
    assign w_mismatch    = (ZN_DUT != w_exp_zn);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ABORT beats START while busy, START wins when idle/done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (ABORT) begin
                    w_state_nxt = S_IDLE;
                end else if (w_settle_last) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (ABORT) begin
                    w_state_nxt = S_IDLE;
                end else if (w_vec_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        w_vec_nxt      = r_vec;
        w_stim_nxt     = r_stim;
        w_cnt_nxt      = r_cnt;
        w_fail_cnt_nxt = r_fail_cnt;
        w_fail_vec_nxt = r_fail_vec;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_stim_nxt = '0;
                if (START) begin
                    w_vec_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_fail_cnt_nxt = '0;
                    w_fail_vec_nxt = '0;
                end
            end
            S_SETTLE: begin
                if (ABORT) begin
                    w_stim_nxt = '0;
                end else if (!w_settle_last) begin
                    w_cnt_nxt = r_cnt + SETTLE_W'(1);
                end
            end
            S_SAMPLE: begin
                if (ABORT) begin
                    w_stim_nxt = '0;
                end else begin
                    if (w_mismatch) begin
                        w_fail_cnt_nxt = r_fail_cnt + FCNT_W'(1);
                        if (r_fail_cnt == '0) begin
                            w_fail_vec_nxt = r_vec;
                        end
                    end
                    if (w_vec_last) begin
                        w_stim_nxt = '0;
                    end else begin
                        w_vec_nxt  = r_vec + VEC_W'(1);
                        w_stim_nxt = r_vec + VEC_W'(1);
                        w_cnt_nxt  = '0;
                    end
                end
            end
            default: w_stim_nxt = '0;
        endcase
        w_busy_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vec      <= '0;
            r_stim     <= '0;
            r_cnt      <= '0;
            r_fail_cnt <= '0;
            r_fail_vec <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_vec      <= w_vec_nxt;
            r_stim     <= w_stim_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fail_cnt <= w_fail_cnt_nxt;
            r_fail_vec <= w_fail_vec_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign A1       = r_stim[3];
    assign A2       = r_stim[2];
    assign B        = r_stim[1];
    assign C        = r_stim[0];
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign PASS     = r_done & (r_fail_cnt == '0);
    assign FAIL_CNT = r_fail_cnt;
    assign FAIL_VEC = r_fail_vec;

endmodule
